// File: rtl/cap_seq_pkg.sv
// Shared definitions for the capacitor charge / IGBT fire sequencer.
// State encoding matches the state_dbg port; fault codes match fault_code.
// Pure declarations, no logic.
package cap_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHARGE   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_FIRE     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_NO_ILK   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILK_LOST = 2'b11;

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// o_tc is combinational from the count: asserted once count >= i_tc.
// No backpressure; counter never wraps, it sticks at all-ones.
module seq_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count enabled cycles; clear has priority; hold at full scale
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt >= i_tc);

endmodule

// File: rtl/cap_charge_sequencer.sv
// Pulse-power shot sequencer: charge, settle, fire IGBT, cooldown, fault.
// Outputs registered from next state: change on the same edge as the state.
// No backpressure; start is a level sampled only in IDLE.
module cap_charge_sequencer
  import cap_seq_pkg::*;
#(
  parameter logic [2:0]  CAP_MASK     = 3'b011,
  parameter logic [31:0] CHG_TIMEOUT  = 32'd50_000_000,
  parameter logic [15:0] SETTLE_CYC   = 16'd50,
  parameter logic [15:0] FIRE_WIDTH   = 16'd500,
  parameter logic [31:0] COOLDOWN_CYC = 32'd5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       fault_clr,
  input  logic       interlock_ok,
  input  logic [2:0] cap_ok,
  output logic [2:0] charge_en,
  output logic       igbt_fire,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_dbg
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_next_code;
  logic        w_done;
  logic        w_caps_ok;
  logic        w_chg_tc;
  logic        w_phase_tc;
  logic [31:0] w_phase_tc_val;

  assign w_caps_ok = ((cap_ok & CAP_MASK) == CAP_MASK);

  // Charge timer spans CHARGE and SETTLE together; only IDLE restarts it
  seq_timer #(.W(32)) u_chg_timer (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_clr (r_state == ST_IDLE),
    .i_en  ((r_state == ST_CHARGE) || (r_state == ST_SETTLE)),
    .i_tc  (CHG_TIMEOUT - 32'd1),
    .o_tc  (w_chg_tc)
  );

  // Phase counter terminal value depends on which timed phase is active
  always_comb begin
    w_phase_tc_val = '1;
    case (r_state)
      ST_SETTLE:   w_phase_tc_val = {16'd0, SETTLE_CYC} - 32'd1;
      ST_FIRE:     w_phase_tc_val = {16'd0, FIRE_WIDTH} - 32'd1;
      ST_COOLDOWN: w_phase_tc_val = COOLDOWN_CYC - 32'd1;
      default:     w_phase_tc_val = '1;
    endcase
  end

  // Shared phase counter restarts on every state change
  seq_timer #(.W(32)) u_phase_timer (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_clr (w_next != r_state),
    .i_en  (1'b1),
    .i_tc  (w_phase_tc_val),
    .o_tc  (w_phase_tc)
  );

  // Next-state decode; priority abort > interlock loss > timeout > normal
  always_comb begin
    w_next      = r_state;
    w_next_code = fault_code;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (interlock_ok) begin
            w_next = ST_CHARGE;
          end else begin
            w_next      = ST_FAULT;
            w_next_code = FC_NO_ILK;
          end
        end
      end
      ST_CHARGE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!interlock_ok) begin
          w_next      = ST_FAULT;
          w_next_code = FC_ILK_LOST;
        end else if (w_chg_tc) begin
          w_next      = ST_FAULT;
          w_next_code = FC_TIMEOUT;
        end else if (w_caps_ok) begin
          w_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!interlock_ok) begin
          w_next      = ST_FAULT;
          w_next_code = FC_ILK_LOST;
        end else if (w_chg_tc) begin
          w_next      = ST_FAULT;
          w_next_code = FC_TIMEOUT;
        end else if (!w_caps_ok) begin
          w_next = ST_CHARGE;
        end else if (w_phase_tc) begin
          w_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!interlock_ok) begin
          w_next      = ST_FAULT;
          w_next_code = FC_ILK_LOST;
        end else if (w_phase_tc) begin
          w_next = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_phase_tc) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_next      = ST_IDLE;
          w_next_code = FC_NONE;
        end
      end
      default: begin
        w_next      = ST_IDLE;
        w_next_code = FC_NONE;
      end
    endcase
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      charge_en  <= 3'b000;
      igbt_fire  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      state_dbg  <= 3'd0;
    end else begin
      r_state    <= w_next;
      charge_en  <= ((w_next == ST_CHARGE) || (w_next == ST_SETTLE)) ? CAP_MASK : 3'b000;
      igbt_fire  <= (w_next == ST_FIRE);
      busy       <= (w_next != ST_IDLE) && (w_next != ST_FAULT);
      done       <= w_done;
      fault      <= (w_next == ST_FAULT);
      fault_code <= w_next_code;
      state_dbg  <= w_next;
    end
  end

endmodule

// File: tb/tb_cap_charge_sequencer.sv
// Directed bench for cap_charge_sequencer with short timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Every expectation below is hand-derived from the edge numbering in comments.
module tb_cap_charge_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       fault_clr = 1'b0;
  logic       interlock_ok = 1'b1;
  logic [2:0] cap_ok = 3'b000;
  logic [2:0] charge_en;
  logic       igbt_fire;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int fire_n;
  int done_n;
  int done_at;

  cap_charge_sequencer #(
    .CAP_MASK     (3'b011),
    .CHG_TIMEOUT  (32'd100),
    .SETTLE_CYC   (16'd4),
    .FIRE_WIDTH   (16'd5),
    .COOLDOWN_CYC (32'd10)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .abort        (abort),
    .fault_clr    (fault_clr),
    .interlock_ok (interlock_ok),
    .cap_ok       (cap_ok),
    .charge_en    (charge_en),
    .igbt_fire    (igbt_fire),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .state_dbg    (state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_chg", 32'(charge_en), 32'd0);
    check("rst_fire", 32'(igbt_fire), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Nominal shot: start at edge 0, caps ok from edge 20, SETTLE 20..23, FIRE from 24
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_chg_e0", 32'(charge_en), 32'd3);
    check("nom_busy_e0", 32'(busy), 32'd1);
    for (int i = 1; i <= 24; i++) begin
      cap_ok = (i >= 20) ? 3'b011 : 3'b000;
      tick();
      if (i == 19) check("nom_st_e19", 32'(state_dbg), 32'd1);
      if (i == 20) check("nom_st_e20", 32'(state_dbg), 32'd2);
      if (i == 23) check("nom_chg_e23", 32'(charge_en), 32'd3);
      if (i == 24) begin
        check("nom_fire_e24", 32'(igbt_fire), 32'd1);
        check("nom_chg_e24", 32'(charge_en), 32'd0);
      end
    end
    // FIRE edges 24..28, COOLDOWN 29..38, done after edge 39 (k=15); start at edge 34 ignored
    fire_n = 1;
    done_n = 0;
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      start = (k == 10);
      tick();
      start = 1'b0;
      if (igbt_fire) fire_n++;
      if (done) begin
        done_n++;
        done_at = k;
      end
      if (k == 10) begin
        check("cd_state", 32'(state_dbg), 32'd4);
        check("cd_busy", 32'(busy), 32'd1);
      end
    end
    check("nom_fire_width", 32'(fire_n), 32'd5);
    check("nom_done_count", 32'(done_n), 32'd1);
    check("nom_done_at", 32'(done_at), 32'd15);
    check("nom_idle", 32'(state_dbg), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", 32'(state_dbg), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_chg_st", 32'(state_dbg), 32'd0);
    check("abort_chg_flt", 32'(fault), 32'd0);

    // Settle glitch: SETTLE after e1, glitch at e3 -> CHARGE, SETTLE e4..e7, FIRE e8
    cap_ok = 3'b011;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("gl_st_e1", 32'(state_dbg), 32'd2);
    tick();
    cap_ok = 3'b001;
    tick();
    check("gl_st_e3", 32'(state_dbg), 32'd1);
    cap_ok = 3'b011;
    tick();
    check("gl_st_e4", 32'(state_dbg), 32'd2);
    tick();
    tick();
    tick();
    check("gl_st_e7", 32'(state_dbg), 32'd2);
    tick();
    check("gl_fire_e8", 32'(igbt_fire), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_fire", 32'(igbt_fire), 32'd0);
    check("abort_fire_st", 32'(state_dbg), 32'd0);
    check("abort_fire_done", 32'(done), 32'd0);

    // Timeout with a brief SETTLE visit at e50..e51; timer keeps running, FAULT at e100
    cap_ok = 3'b001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      cap_ok = (e == 50 || e == 51) ? 3'b011 : 3'b001;
      tick();
      if (e == 51) check("to_settle_e51", 32'(state_dbg), 32'd2);
      if (e == 99) check("to_chg_e99", 32'(state_dbg), 32'd1);
      if (e == 100) begin
        check("to_state", 32'(state_dbg), 32'd5);
        check("to_code", 32'(fault_code), 32'd2);
        check("to_chg", 32'(charge_en), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("flt_hold_st", 32'(state_dbg), 32'd5);
    check("flt_hold_code", 32'(fault_code), 32'd2);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fclr_st", 32'(state_dbg), 32'd0);
    check("fclr_code", 32'(fault_code), 32'd0);

    // Interlock loss at FIRE cycle 2: FIRE after e5, drop before e7
    cap_ok = 3'b011;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    check("ilk_fire_e5", 32'(igbt_fire), 32'd1);
    tick();
    interlock_ok = 1'b0;
    tick();
    check("ilk_fire_off", 32'(igbt_fire), 32'd0);
    check("ilk_code", 32'(fault_code), 32'd3);
    interlock_ok = 1'b1;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    interlock_ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("noilk_st", 32'(state_dbg), 32'd5);
    check("noilk_code", 32'(fault_code), 32'd1);
    interlock_ok = 1'b1;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("noilk_clr", 32'(state_dbg), 32'd0);

    // Abort and interlock drop together in SETTLE: abort wins
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sim_settle", 32'(state_dbg), 32'd2);
    abort = 1'b1;
    interlock_ok = 1'b0;
    tick();
    abort = 1'b0;
    interlock_ok = 1'b1;
    check("sim_st", 32'(state_dbg), 32'd0);
    check("sim_flt", 32'(fault), 32'd0);

    // Asynchronous reset mid-FIRE
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    check("rst_pre_fire", 32'(igbt_fire), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_fire", 32'(igbt_fire), 32'd0);
    check("arst_chg", 32'(charge_en), 32'd0);
    check("arst_st", 32'(state_dbg), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
